// File: rtl/riscv_multicycle.sv
// Multi-cycle RV32I core with a single shared memory port and req/ack handshake.
// FETCH -> DECODE -> EXEC -> (MEM -> (WB)) sequencing; any fault parks the core in HALT until reset.
module riscv_multicycle #(
    parameter int XLEN = 32,
    parameter int ADDR = 16,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [ADDR-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [ADDR-1:0] pc_o,
    output logic            retire,
    output logic            halt
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [ADDR-1:0] PC_STEP = ADDR'(4);

    state_e          state_q;
    logic [ADDR-1:0] pc_q, mem_addr_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q, b_q, imm_q, ldata_q, mem_wdata_q;
    logic            mem_req_q, mem_we_q;
    logic [XLEN-1:0] rf_q [0:31];

    logic [6:0] opc_s, f7_s;
    logic [2:0] f3_s;
    logic [4:0] rd_s, rs1_s, rs2_s;
    assign opc_s = ir_q[6:0];
    assign rd_s  = ir_q[11:7];
    assign f3_s  = ir_q[14:12];
    assign rs1_s = ir_q[19:15];
    assign rs2_s = ir_q[24:20];
    assign f7_s  = ir_q[31:25];

    logic            legal_s;
    logic [XLEN-1:0] imm_s;

    // Immediate construction and encoding legality of the latched instruction
    always_comb begin
        legal_s = 1'b0;
        imm_s   = {{20{ir_q[31]}}, ir_q[31:20]};
        case (opc_s)
            OP_LUI, OP_AUIPC: begin
                legal_s = 1'b1;
                imm_s   = {ir_q[31:12], 12'h000};
            end
            OP_JAL: begin
                legal_s = 1'b1;
                imm_s   = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            OP_JALR:  legal_s = (f3_s == 3'b000);
            OP_BR: begin
                legal_s = (f3_s != 3'b010) && (f3_s != 3'b011);
                imm_s   = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            OP_LOAD:  legal_s = (f3_s == 3'b010);
            OP_STORE: begin
                legal_s = (f3_s == 3'b010);
                imm_s   = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
            end
            OP_IMM: begin
                case (f3_s)
                    3'b001:  legal_s = (f7_s == 7'h00);
                    3'b101:  legal_s = (f7_s == 7'h00) || (f7_s == 7'h20);
                    default: legal_s = 1'b1;
                endcase
            end
            OP_REG:   legal_s = (f7_s == 7'h00) ||
                                ((f7_s == 7'h20) && ((f3_s == 3'b000) || (f3_s == 3'b101)));
            default:  legal_s = 1'b0;
        endcase
    end

    logic [XLEN-1:0] opb_s, alu_s, res_s, pc_x_s;
    logic [ADDR-1:0] pc4_s, jt_s, rt_s, npc_s;
    logic [4:0]      shamt_s;
    logic            alt_s, taken_s, fault_s, wb_s, ldst_s;

    assign opb_s   = (opc_s == OP_REG) ? b_q : imm_q;
    assign shamt_s = opb_s[4:0];
    assign alt_s   = ir_q[30] && ((opc_s == OP_REG) || (f3_s == 3'b101));
    assign pc_x_s  = {{(XLEN-ADDR){1'b0}}, pc_q};
    assign pc4_s   = pc_q + PC_STEP;
    assign jt_s    = pc_q + imm_q[ADDR-1:0];
    // rs1+imm serves as both the JALR target and the load/store effective address
    assign rt_s    = a_q[ADDR-1:0] + imm_q[ADDR-1:0];
    assign ldst_s  = (opc_s == OP_LOAD) || (opc_s == OP_STORE);

    // ALU for OP / OP-IMM
    always_comb begin
        alu_s = '0;
        case (f3_s)
            3'b000:  alu_s = alt_s ? (a_q - opb_s) : (a_q + opb_s);
            3'b001:  alu_s = a_q << shamt_s;
            3'b010:  alu_s = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(opb_s))};
            3'b011:  alu_s = {{(XLEN-1){1'b0}}, (a_q < opb_s)};
            3'b100:  alu_s = a_q ^ opb_s;
            3'b101:  alu_s = alt_s ? XLEN'($signed(a_q) >>> shamt_s) : (a_q >> shamt_s);
            3'b110:  alu_s = a_q | opb_s;
            3'b111:  alu_s = a_q & opb_s;
            default: alu_s = '0;
        endcase
    end

    // Branch condition
    always_comb begin
        taken_s = 1'b0;
        case (f3_s)
            3'b000:  taken_s = (a_q == b_q);
            3'b001:  taken_s = (a_q != b_q);
            3'b100:  taken_s = ($signed(a_q) <  $signed(b_q));
            3'b101:  taken_s = ($signed(a_q) >= $signed(b_q));
            3'b110:  taken_s = (a_q <  b_q);
            3'b111:  taken_s = (a_q >= b_q);
            default: taken_s = 1'b0;
        endcase
    end

    // EXEC outcome: next PC, rd result and alignment faults
    always_comb begin
        npc_s   = pc4_s;
        fault_s = 1'b0;
        wb_s    = 1'b0;
        res_s   = alu_s;
        case (opc_s)
            OP_LUI: begin
                wb_s  = 1'b1;
                res_s = imm_q;
            end
            OP_AUIPC: begin
                wb_s  = 1'b1;
                res_s = pc_x_s + imm_q;
            end
            OP_JAL: begin
                wb_s    = 1'b1;
                res_s   = {{(XLEN-ADDR){1'b0}}, pc4_s};
                npc_s   = jt_s;
                fault_s = (jt_s[1:0] != 2'b00);
            end
            OP_JALR: begin
                wb_s    = 1'b1;
                res_s   = {{(XLEN-ADDR){1'b0}}, pc4_s};
                npc_s   = {rt_s[ADDR-1:1], 1'b0};
                fault_s = rt_s[1];
            end
            OP_BR: begin
                if (taken_s) begin
                    npc_s   = jt_s;
                    fault_s = (jt_s[1:0] != 2'b00);
                end else begin
                    npc_s   = pc4_s;
                end
            end
            OP_LOAD, OP_STORE: fault_s = (rt_s[1:0] != 2'b00);
            OP_IMM, OP_REG:    wb_s = 1'b1;
            default:           fault_s = 1'b1;
        endcase
    end

    logic            rf_we_s;
    logic [XLEN-1:0] rf_wd_s;
    assign rf_we_s = ((state_q == S_EXEC) && wb_s && !fault_s) || (state_q == S_WB);
    assign rf_wd_s = (state_q == S_WB) ? ldata_q : res_s;

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we_s && (rd_s != 5'd0)) begin
            rf_q[rd_s] <= rf_wd_s;
        end
    end

    // Control sequencer with registered memory-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            ldata_q     <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= RESET_PC;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q      <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rf_q[rs1_s];
                    b_q     <= rf_q[rs2_s];
                    imm_q   <= imm_s;
                    state_q <= legal_s ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    if (fault_s) begin
                        state_q <= S_HALT;
                    end else if (ldst_s) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (opc_s == OP_STORE);
                        mem_addr_q  <= rt_s;
                        mem_wdata_q <= b_q;
                        state_q     <= S_MEM;
                    end else begin
                        pc_q       <= npc_s;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= npc_s;
                        state_q    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ack && mem_we_q) begin
                        pc_q       <= pc4_s;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc4_s;
                        state_q    <= S_FETCH;
                    end else if (mem_ack) begin
                        ldata_q   <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    pc_q       <= pc4_s;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc4_s;
                    state_q    <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end

    // retire depends on the same-cycle ack for stores, so it is decoded from state
    assign retire    = ((state_q == S_EXEC) && !fault_s && !ldst_s) ||
                       ((state_q == S_MEM) && mem_ack && mem_we_q) ||
                       (state_q == S_WB);
    assign halt      = (state_q == S_HALT);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc_o      = pc_q;
endmodule

// File: tb/tb_riscv_multicycle.sv
// Bench for riscv_multicycle: word memory with random wait states, a queue of expected
// stores, per-instruction cycle counting and directed reset/fault scenarios.
module tb_riscv_multicycle;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack = 1'b0, retire, halt;
    logic [15:0] mem_addr, pc_o;
    logic [31:0] mem_wdata, mem_rdata = 32'h0;

    riscv_multicycle #(.XLEN(32), .ADDR(16), .RESET_PC(16'h0100)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pc_o(pc_o), .retire(retire), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
    logic [31:0] mem [0:1023];
    wr_t exp_q[$];
    int errors = 0, checks = 0;
    int max_wait = 0, wait_left = 0, cyc_cnt = 0, wait_cnt = 0, hs_cnt = 0, ret_cnt = 0;
    bit block_wr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [31:0] rs1,
                                         input logic [2:0] f3, input logic [31:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction
    function automatic logic [31:0] addi(input logic [31:0] rd, rs1, imm);
        return i_t(imm, rs1, 3'b000, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lw(input logic [31:0] rd, rs1, imm);
        return i_t(imm, rs1, 3'b010, rd, 7'h03);
    endfunction
    function automatic logic [31:0] jalr(input logic [31:0] rd, rs1, imm);
        return i_t(imm, rs1, 3'b000, rd, 7'h67);
    endfunction
    function automatic logic [31:0] srai(input logic [31:0] rd, rs1, sh);
        return {7'h20, sh[4:0], rs1[4:0], 3'b101, rd[4:0], 7'h13};
    endfunction
    function automatic logic [31:0] sw(input logic [31:0] rs2, rs1, imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [31:0] rd, rs1, rs2,
                                          input logic [2:0] f3);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] lui(input logic [31:0] rd, imm20);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [31:0] rs1, rs2, off);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3, off[4:1], off[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [31:0] rd, off);
        return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6F};
    endfunction

    // Memory responder, then end-of-cycle monitor for handshakes, stores and CPI
    always begin
        @(negedge clk);
        if (mem_req && !(block_wr && mem_we) && wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[11:2]];
        end else if (mem_req) begin
            mem_ack = 1'b0;
            if (wait_left > 0) wait_left--;
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
        end
        #1;
        if (reset) begin
            wait_left = $urandom_range(0, max_wait);
            cyc_cnt = 0; wait_cnt = 0; hs_cnt = 0; ret_cnt = 0;
        end else begin
            cyc_cnt++;
            if (mem_req && !mem_ack) wait_cnt++;
            if (retire) begin
                logic [6:0] op;
                int base;
                op = mem[pc_o[11:2]][6:0];
                base = (op == 7'h03) ? 5 : (op == 7'h23) ? 4 : 3;
                check_eq("cpi", 32'(cyc_cnt), 32'(base + wait_cnt));
                ret_cnt++; cyc_cnt = 0; wait_cnt = 0;
            end
            if (mem_req && mem_ack) begin
                hs_cnt++;
                if (mem_we) begin
                    if (exp_q.size() == 0) begin
                        check_eq("wr_extra", {16'h0, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check_eq("wr_addr", {16'h0, mem_addr}, {16'h0, e.addr});
                        check_eq("wr_data", mem_wdata, e.data);
                    end
                    mem[mem_addr[11:2]] = mem_wdata;
                end
                wait_left = $urandom_range(0, max_wait);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        exp_q.delete();
    endtask
    task automatic put(input logic [15:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
    endtask
    task automatic expect_wr(input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        reset = 1'b0;
        #2;
    endtask
    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
        check_eq("drain", 32'(exp_q.size()), 32'h0);
    endtask
    task automatic halt_test(input string tag, input logic [31:0] word);
        clear_mem();
        put(16'h0100, word);
        do_reset();
        repeat (10) cyc();
        check_eq({tag, "_halt"}, {31'h0, halt}, 32'h1);
        repeat (100) cyc();
        check_eq({tag, "_halt100"}, {31'h0, halt}, 32'h1);
        check_eq({tag, "_req"}, {31'h0, mem_req}, 32'h0);
        check_eq({tag, "_hs"}, 32'(hs_cnt), 32'h1);
        check_eq({tag, "_ret"}, 32'(ret_cnt), 32'h0);
        reset = 1'b1;
        cyc();
        check_eq({tag, "_clr"}, {31'h0, halt}, 32'h0);
    endtask

    initial begin
        int found;
        // zero-wait program: ALU, branches, jalr, x0, shifts
        clear_mem();
        put(16'h0100, addi(1, 0, 5));            put(16'h0104, sw(1, 0, 32'h40));
        put(16'h0108, addi(1, 0, -1));           put(16'h010C, addi(2, 0, 1));
        put(16'h0110, br(3'b100, 1, 2, 16));     put(16'h0114, sw(1, 0, 32'h70));
        put(16'h0118, sw(1, 0, 32'h70));         put(16'h011C, sw(1, 0, 32'h70));
        put(16'h0120, br(3'b110, 1, 2, 16));     put(16'h0124, addi(6, 0, 32'h55));
        put(16'h0128, sw(6, 0, 32'h44));         put(16'h012C, jalr(5, 0, 32'h201));
        put(16'h0130, sw(1, 0, 32'h70));
        put(16'h0200, sw(5, 0, 32'h48));         put(16'h0204, addi(0, 0, 7));
        put(16'h0208, rtype(7'h00, 4, 0, 0, 3'b000)); put(16'h020C, sw(4, 0, 32'h4C));
        put(16'h0210, lui(7, 32'h80000));        put(16'h0214, srai(8, 7, 31));
        put(16'h0218, sw(8, 0, 32'h50));         put(16'h021C, addi(9, 0, 33));
        put(16'h0220, rtype(7'h00, 11, 7, 9, 3'b101)); put(16'h0224, sw(11, 0, 32'h54));
        put(16'h0228, rtype(7'h20, 12, 2, 1, 3'b000)); put(16'h022C, sw(12, 0, 32'h58));
        put(16'h0230, jal(0, 0));
        expect_wr(16'h0040, 32'd5);          expect_wr(16'h0044, 32'h55);
        expect_wr(16'h0048, 32'h130);        expect_wr(16'h004C, 32'h0);
        expect_wr(16'h0050, 32'hFFFF_FFFF);  expect_wr(16'h0054, 32'h4000_0000);
        expect_wr(16'h0058, 32'd2);
        max_wait = 0;
        reset = 1'b1;
        repeat (2) cyc();
        check_eq("rst_req", {31'h0, mem_req}, 32'h1);
        check_eq("rst_we", {31'h0, mem_we}, 32'h0);
        check_eq("rst_addr", {16'h0, mem_addr}, 32'h0100);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_retire", {31'h0, retire}, 32'h0);
        check_eq("rst_halt", {31'h0, halt}, 32'h0);
        check_eq("rst_pc", {16'h0, pc_o}, 32'h0100);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_eq("c1_fetch", {15'h0, mem_req, mem_addr}, 32'h1_0100);
        cyc();
        check_eq("c2_retire", {31'h0, retire}, 32'h0);
        cyc();
        check_eq("c3_retire", {31'h0, retire}, 32'h1);
        cyc();
        check_eq("c4_fetch", {15'h0, mem_req, mem_addr}, 32'h1_0104);
        check_eq("c4_pc", {16'h0, pc_o}, 32'h0104);
        wait_drain(2000);

        // store/load round trip with random wait states
        clear_mem();
        put(16'h0100, lui(2, 32'h12345));  put(16'h0104, addi(2, 2, 32'h678));
        put(16'h0108, sw(2, 0, 32'h8));    put(16'h010C, lw(3, 0, 32'h8));
        put(16'h0110, sw(3, 0, 32'h40));   put(16'h0114, jal(0, 0));
        expect_wr(16'h0008, 32'h1234_5678);
        expect_wr(16'h0040, 32'h1234_5678);
        max_wait = 3;
        do_reset();
        wait_drain(2000);

        halt_test("misal_lw", lw(1, 0, 32'h2));
        halt_test("bad_opc", 32'h0000_007F);

        // reset while a store is stalled: no write, restart at reset PC, registers cleared
        clear_mem();
        put(16'h0100, addi(1, 0, 9));
        put(16'h0104, sw(1, 0, 32'h60));
        max_wait = 2;
        block_wr = 1'b1;
        do_reset();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (mem_req && mem_we) found = 1;
            else cyc();
        end
        check_eq("st_issued", 32'(found), 32'h1);
        repeat (5) cyc();
        check_eq("st_hold", {14'h0, mem_req, mem_we, mem_addr}, 32'h3_0060);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst", {14'h0, mem_req, mem_we, mem_addr}, 32'h2_0100);
        check_eq("mid_rst_pc", {16'h0, pc_o}, 32'h0100);
        clear_mem();
        put(16'h0100, sw(1, 0, 32'h64));
        put(16'h0104, jal(0, 0));
        expect_wr(16'h0064, 32'h0);
        block_wr = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        reset = 1'b0;
        wait_drain(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
